// File: rtl/fetch_pkg.sv
// Shared types and default widths for the dual-issue fetch stage.
package fetch_pkg;

   localparam int FETCH_ADDR_W  = 10;
   localparam int FETCH_INSTR_W = 32;

   typedef struct packed {
      logic [FETCH_INSTR_W-1:0] instr1;
      logic [FETCH_INSTR_W-1:0] instr2;
      logic [FETCH_ADDR_W-1:0]  pc1;
      logic [FETCH_ADDR_W-1:0]  pc2;
   } fetch_pair_t;

   typedef enum logic [1:0] {BOOT, RUN, FULL, FLUSH} fetch_state_t;

endpackage

// File: rtl/fetch_pair_fifo.sv
// DEPTH-entry FIFO of instruction pairs; clear dominates push and pop.
module fetch_pair_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  fetch_pair_t              push_data,
   input  logic                     pop,
   input  logic                     clear,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output fetch_pair_t              head
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_pair_t      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage is reset so the head reads as zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Dual-issue fetch stage: owns the PC, drives ROM pair addresses, buffers pairs for decode.
// Optional performance counters are enabled with FETCH_PERF_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W  = FETCH_ADDR_W,
   parameter int INSTR_W = FETCH_INSTR_W,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [ADDR_W-1:0]  rom_addr1,
   output logic [ADDR_W-1:0]  rom_addr2,
   input  logic [INSTR_W-1:0] rom_instr1,
   input  logic [INSTR_W-1:0] rom_instr2,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr1,
   output logic [INSTR_W-1:0] out_instr2,
   output logic [ADDR_W-1:0]  out_pc1,
   output logic [ADDR_W-1:0]  out_pc2
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        perf_stall_cnt,
   output logic [31:0]        perf_redirect_cnt
`endif
);

   localparam int               CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(DEPTH);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] req_pc;
   logic              inflight;
   logic [CNT_W-1:0]  count;
   logic              empty;
   logic              push;
   logic              pop;
   logic              issue;
   logic [CNT_W:0]    used_now;
   logic [CNT_W:0]    used_next;
   fetch_pair_t       push_data;
   fetch_pair_t       head;

   assign rom_addr1 = pc;
   assign rom_addr2 = pc + 1'b1;

   // Credit = buffered pairs plus the one request that may still be in the ROM.
   assign used_now  = {1'b0, count} + (CNT_W+1)'(inflight);
   assign issue     = (state == RUN) && (used_now < DEPTH_C);
   assign push      = inflight && !redirect_valid;
   assign pop       = out_valid && out_ready;
   assign used_next = {1'b0, count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop) + (CNT_W+1)'(issue);

   assign push_data.instr1 = rom_instr1;
   assign push_data.instr2 = rom_instr2;
   assign push_data.pc1    = req_pc;
   assign push_data.pc2    = req_pc + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= BOOT;
         pc       <= '0;
         req_pc   <= '0;
         inflight <= 1'b0;
      end else if (redirect_valid) begin
         state    <= FLUSH;
         pc       <= redirect_pc;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc     <= pc + ADDR_W'(2);
            req_pc <= pc;
         end
         case (state)
            BOOT, FLUSH: state <= RUN;
            default:     state <= (used_next < DEPTH_C) ? RUN : FULL;
         endcase
      end
   end

   fetch_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .clear     (redirect_valid),
      .count     (count),
      .empty     (empty),
      .head      (head)
   );

   assign out_valid  = !empty;
   assign out_instr1 = head.instr1;
   assign out_instr2 = head.instr2;
   assign out_pc1    = head.pc1;
   assign out_pc2    = head.pc2;

`ifdef FETCH_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt    <= '0;
         perf_redirect_cnt <= '0;
      end else begin
         if (state == FULL || (out_valid && !out_ready))
            perf_stall_cnt <= sat_inc(perf_stall_cnt);
         if (redirect_valid)
            perf_redirect_cnt <= sat_inc(perf_redirect_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected pair stream queued per (re)start, monitor pops on handshake.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  rom_addr1;
   logic [9:0]  rom_addr2;
   logic [31:0] rom_instr1;
   logic [31:0] rom_instr2;
   logic        redirect_valid;
   logic [9:0]  redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr1;
   logic [31:0] out_instr2;
   logic [9:0]  out_pc1;
   logic [9:0]  out_pc2;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_redirect_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int pops = 0;
   int exp_stall = 0;
   int exp_q[$];
   int e_pc;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rom_addr1      (rom_addr1),
      .rom_addr2      (rom_addr2),
      .rom_instr1     (rom_instr1),
      .rom_instr2     (rom_instr2),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr1     (out_instr1),
      .out_instr2     (out_instr2),
      .out_pc1        (out_pc1),
      .out_pc2        (out_pc2)
`ifdef FETCH_PERF_EN
      ,
      .perf_stall_cnt    (perf_stall_cnt),
      .perf_redirect_cnt (perf_redirect_cnt)
`endif
   );

   // Synchronous-read ROM: word at address a is A000_0000 | a.
   always @(posedge clk) begin
      rom_instr1 <= 32'hA000_0000 | {22'd0, rom_addr1};
      rom_instr2 <= 32'hA000_0000 | {22'd0, rom_addr2};
   end

   function automatic logic [31:0] rom_word(input int a);
      return 32'hA000_0000 | 32'(a % 1024);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Fetch from `start` yields pairs start, start+2, ... in order, wrapping mod 1024.
   task automatic restart(input int start);
      exp_q.delete();
      for (int i = 0; i < 600; i++) exp_q.push_back((start + 2 * i) % 1024);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset(input logic ready);
      rst_n = 1'b0;
      out_ready = ready;
      redirect_valid = 1'b0;
      tick();
      exp_stall = 0;
      restart(0);
      rst_n = 1'b1;
   endtask

   task automatic do_redirect(input logic [9:0] target);
      redirect_valid = 1'b1;
      redirect_pc = target;
      restart(int'(target));
      tick();
      redirect_valid = 1'b0;
   endtask

   // Monitor: a pop is a handshake with no redirect overriding it.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b0) exp_stall++;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && redirect_valid === 1'b0) begin
         pops++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_underflow actual=pc %0d expected=no pair", out_pc1);
         end else begin
            e_pc = exp_q.pop_front();
            check("pair_pc1", 32'(out_pc1), 32'(e_pc));
            check("pair_pc2", 32'(out_pc2), 32'((e_pc + 1) % 1024));
            check("pair_instr1", out_instr1, rom_word(e_pc));
            check("pair_instr2", out_instr2, rom_word(e_pc + 1));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit seen;
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      out_ready = 1'b0;
      #12;
      check("rst_addr1", 32'(rom_addr1), 32'd0);
      check("rst_addr2", 32'(rom_addr2), 32'd1);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_instr1", out_instr1, 32'd0);
      check("rst_instr2", out_instr2, 32'd0);
      check("rst_pc1", 32'(out_pc1), 32'd0);
      check("rst_pc2", 32'(out_pc2), 32'd0);

      // Fill with decode stalled, then drain in order.
      restart(0);
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      check("fill_addr_hold", 32'(rom_addr1), 32'd8);
      check("fill_valid", 32'(out_valid), 32'd1);
      check("fill_head_pc", 32'(out_pc1), 32'd0);
      out_ready = 1'b1;
      repeat (6) tick();
      for (int i = 0; i < 4; i++) begin
         check("stream_gapless", 32'(out_valid), 32'd1);
         tick();
      end

      // Redirect to 13 with three pairs buffered.
      pulse_reset(1'b0);
      repeat (5) tick();
      check("pre_redir_valid", 32'(out_valid), 32'd1);
      do_redirect(10'd13);
      check("redir_empty", 32'(out_valid), 32'd0);
      check("redir_addr1", 32'(rom_addr1), 32'd13);
      tick();
      check("redir_lat1", 32'(out_valid), 32'd0);
      tick();
      check("redir_lat2", 32'(out_valid), 32'd0);
      tick();
      check("redir_lat3", 32'(out_valid), 32'd1);
      check("redir_head_pc", 32'(out_pc1), 32'd13);
      check("redir_head_instr", out_instr1, 32'hA000_000D);
      out_ready = 1'b1;
      repeat (6) tick();

      // Address wrap.
      do_redirect(10'd1022);
      repeat (8) tick();
      do_redirect(10'd1023);
      check("wrap_addr1", 32'(rom_addr1), 32'd1023);
      check("wrap_addr2", 32'(rom_addr2), 32'd0);
      repeat (8) tick();

      // Asynchronous reset mid-stream, with redirect asserted alongside.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 10'd500;
      #1;
      check("async_valid", 32'(out_valid), 32'd0);
      check("async_pc1", 32'(out_pc1), 32'd0);
      check("async_addr1", 32'(rom_addr1), 32'd0);
      check("async_addr2", 32'(rom_addr2), 32'd1);
      tick();
      tick();
      restart(0);
      rst_n = 1'b1;
      redirect_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (out_valid === 1'b1) seen = 1'b1;
      end
      check("restart_seen", 32'(seen), 32'd1);
      check("restart_pc", 32'(out_pc1), 32'd0);

      // Randomized backpressure and redirects.
      pops = 0;
      for (int i = 0; i < 400; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc = 10'($urandom_range(0, 1023));
            restart(int'(redirect_pc));
         end else begin
            redirect_valid = 1'b0;
         end
         tick();
      end
      redirect_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
      check("random_progress", 32'(pops > 100), 32'd1);

`ifdef FETCH_PERF_EN
      pulse_reset(1'b1);
      repeat (6) tick();
      for (int k = 0; k < 5; k++) begin
         out_ready = 1'b0;
         tick();
         out_ready = 1'b1;
         do_redirect(10'($urandom_range(0, 1023)));
         repeat (6) tick();
      end
      check("perf_stall", perf_stall_cnt, 32'(exp_stall));
      check("perf_stall_five", perf_stall_cnt, 32'd5);
      check("perf_redirect", perf_redirect_cnt, 32'd5);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
